// File: rtl/fetch_pkg.sv
// Shared types for the instruction-fetch stage: queue entry layout and FSM states.
package fetch_pkg;

  localparam int unsigned XLEN = 32;

  // Marks an entry that carries a fetch address-error instead of an instruction.
  localparam logic EXC_ADEL = 1'b1;

  typedef enum logic {
    S_IDLE = 1'b0,
    S_REQ  = 1'b1
  } fetch_state_t;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] instr;
    logic            exc_adel;
  } fetch_entry_t;

endpackage

// File: rtl/fetch_fifo.sv
// Synchronous FIFO with clear; head is presented combinationally and reads as zero when empty.
module fetch_fifo #(
  parameter type         T     = logic,
  parameter int unsigned DEPTH = 4,
  localparam int unsigned PTR_W = $clog2(DEPTH),
  localparam int unsigned CNT_W = PTR_W + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  T                 din,
  input  logic             pop,
  input  logic             clear,
  output T                 dout,
  output logic             full,
  output logic             empty,
  output logic [CNT_W-1:0] count
);

  T                 mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic             do_push;
  logic             do_pop;

  // A push into a full FIFO is accepted only when the head leaves in the same cycle.
  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | do_pop);

  always_ff @(posedge clk) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (clear) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (do_pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      count <= count + CNT_W'(do_push) - CNT_W'(do_pop);
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

  assign full  = (count == CNT_W'(DEPTH));
  assign empty = (count == '0);
  assign dout  = empty ? '0 : mem[rd_ptr];

endmodule

// File: rtl/if_fetch_unit.sv
// Instruction-fetch stage: issues memory requests for IF_PC, buffers responses in order
// for decode, and drives IF_PCWr so the PC only steps on an accepted fetch or a redirect.
module if_fetch_unit
  import fetch_pkg::*;
#(
  parameter int unsigned DEPTH   = 4,
  parameter int unsigned MAX_OUT = 2,
  parameter int unsigned PC_W    = XLEN
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [PC_W-1:0] IF_PC,
  output logic            IF_PCWr,
  input  logic            flush,
  output logic            inst_req,
  output logic [PC_W-1:0] inst_addr,
  input  logic            inst_addr_ok,
  input  logic            inst_data_ok,
  input  logic [PC_W-1:0] inst_rdata,
  input  logic            ID_Ready,
  output logic            ID_Valid,
  output logic [PC_W-1:0] ID_Instr,
  output logic [PC_W-1:0] ID_PC,
  output logic            ID_ExcAdEL
);

  localparam int unsigned Q_CW  = $clog2(DEPTH) + 1;
  localparam int unsigned P_CW  = $clog2(MAX_OUT) + 1;
  localparam int unsigned OUT_W = $clog2(MAX_OUT + 1);

  fetch_state_t     state_q, state_d;
  logic [PC_W-1:0]  addr_q, addr_d;
  logic             stale_q, stale_d;
  logic [OUT_W-1:0] out_q, out_d;
  logic [OUT_W-1:0] disc_q, disc_d;

  logic             q_push, q_pop, q_full, q_empty;
  logic [Q_CW-1:0]  q_count;
  fetch_entry_t     q_din, q_dout;

  logic             p_push, p_pop, p_full, p_empty;
  logic [P_CW-1:0]  p_count;
  logic [PC_W-1:0]  p_dout;

  logic             accept;
  logic             space;
  logic             pcwr_c;
  logic             unused_status;

  assign accept = (state_q == S_REQ) & inst_addr_ok;

  // Reserve a slot for every buffered, in-flight and about-to-issue fetch.
  assign space = ((32'(q_count) + 32'(out_q) + 32'(state_q == S_REQ)) < DEPTH) &&
                 (32'(out_q) < MAX_OUT);

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    stale_d = stale_q;
    out_d   = out_q + OUT_W'(accept) - OUT_W'(inst_data_ok);
    disc_d  = disc_q;
    pcwr_c  = 1'b0;
    q_push  = 1'b0;
    q_din   = '0;
    p_push  = 1'b0;
    p_pop   = 1'b0;

    if (flush) begin
      // Everything in flight, including a request accepted right now, becomes garbage.
      pcwr_c = 1'b1;
      disc_d = out_q - OUT_W'(inst_data_ok) + OUT_W'(accept);
      if (accept)                  state_d = S_IDLE;
      else if (state_q == S_REQ)   stale_d = 1'b1;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (space) begin
            if (IF_PC[1:0] != 2'b00) begin
              // Wait for older fetches to drain so the error entry stays in program order.
              if (out_q == '0) begin
                q_push = 1'b1;
                q_din  = '{pc: IF_PC, instr: '0, exc_adel: EXC_ADEL};
                pcwr_c = 1'b1;
              end
            end else begin
              addr_d  = IF_PC;
              stale_d = 1'b0;
              state_d = S_REQ;
            end
          end
        end
        S_REQ: begin
          if (accept) begin
            state_d = S_IDLE;
            if (stale_q) begin
              disc_d = disc_q + OUT_W'(1);
            end else begin
              pcwr_c = 1'b1;
              p_push = 1'b1;
            end
          end
        end
        default: state_d = S_IDLE;
      endcase

      if (inst_data_ok) begin
        if (disc_q != '0) begin
          disc_d = disc_d - OUT_W'(1);
        end else begin
          p_pop  = 1'b1;
          q_push = 1'b1;
          q_din  = '{pc: p_dout, instr: inst_rdata, exc_adel: 1'b0};
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= S_IDLE;
      addr_q  <= '0;
      stale_q <= 1'b0;
      out_q   <= '0;
      disc_q  <= '0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      stale_q <= stale_d;
      out_q   <= out_d;
      disc_q  <= disc_d;
    end
  end

  fetch_fifo #(
    .T     (fetch_entry_t),
    .DEPTH (DEPTH)
  ) u_iq (
    .clk   (clk),
    .rst   (rst),
    .push  (q_push),
    .din   (q_din),
    .pop   (q_pop),
    .clear (flush),
    .dout  (q_dout),
    .full  (q_full),
    .empty (q_empty),
    .count (q_count)
  );

  fetch_fifo #(
    .T     (logic [PC_W-1:0]),
    .DEPTH (MAX_OUT)
  ) u_pend (
    .clk   (clk),
    .rst   (rst),
    .push  (p_push),
    .din   (addr_q),
    .pop   (p_pop),
    .clear (flush),
    .dout  (p_dout),
    .full  (p_full),
    .empty (p_empty),
    .count (p_count)
  );

  assign unused_status = ^{q_full, p_full, p_empty, p_count};

  assign q_pop      = ID_Valid & ID_Ready & ~flush;
  assign IF_PCWr    = rst & pcwr_c;
  assign inst_req   = (state_q == S_REQ);
  assign inst_addr  = addr_q;
  assign ID_Valid   = ~q_empty;
  assign ID_PC      = q_dout.pc;
  assign ID_Instr   = q_dout.instr;
  assign ID_ExcAdEL = q_dout.exc_adel;

endmodule
